// File: rtl/pcm_channel_sequencer.sv
// Time-multiplexed PCM voice sequencer: per-channel 8/16-bit sample fetch with
// fractional pitch stepping, end-marker detection and optional looping.
module pcm_channel_sequencer #(
   parameter int unsigned CHANNELS = 8,
   parameter int unsigned ADDR_W   = 24
) (
   input  logic                CLK,
   input  logic                RES,
   input  logic                REG_WE,
   input  logic [3:0]          REG_CH,
   input  logic [3:0]          REG_SEL,
   input  logic [7:0]          REG_DATA,
   input  logic                SAMPLE_TICK,
   output logic                ROM_REQ,
   output logic [ADDR_W-1:0]   ROM_ADDR,
   input  logic                ROM_ACK,
   input  logic [7:0]          ROM_DATA,
   output logic                OUT_VALID,
   output logic [3:0]          OUT_CH,
   output logic [15:0]         OUT_SAMPLE,
   output logic [CHANNELS-1:0] ACTIVE,
   output logic                BUSY,
   output logic                OVERRUN
);

   localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   typedef enum logic [2:0] {IDLE, SCAN, FETCH_LO, FETCH_HI, EMIT} state_t;

   state_t              state;
   logic [CH_W-1:0]     ch;
   logic [ADDR_W-1:0]   start_r [CHANNELS];
   logic [ADDR_W-1:0]   loop_r  [CHANNELS];
   logic [15:0]         pitch_r [CHANNELS];
   logic [1:0]          mode_r  [CHANNELS];
   logic [ADDR_W-1:0]   cur_r   [CHANNELS];
   logic [11:0]         frac_r  [CHANNELS];

   logic [ADDR_W-1:0]   w_cur;
   logic [11:0]         w_frac;
   logic [15:0]         w_pitch;
   logic [1:0]          w_mode;
   logic                w_active;
   logic                w_end;
   logic [7:0]          w_lo;
   logic                dirty;

   logic                wr_hit;
   logic [CH_W-1:0]     wr_ch;
   logic                key_hit;
   logic [16:0]         sum;
   logic [ADDR_W-1:0]   step;
   logic [15:0]         hi_word;

   assign wr_hit  = REG_WE && (5'(REG_CH) < 5'(CHANNELS));
   assign wr_ch   = REG_CH[CH_W-1:0];
   assign key_hit = wr_hit && (REG_SEL == 4'd9);
   assign sum     = 17'(w_frac) + 17'(w_pitch);
   assign step    = w_mode[0] ? ADDR_W'({sum[16:12], 1'b0}) : ADDR_W'(sum[16:12]);
   assign hi_word = {ROM_DATA, w_lo};

   // Replace one byte of an address register; bits above ADDR_W fall away.
   function automatic logic [ADDR_W-1:0] set_byte(input logic [ADDR_W-1:0] old,
                                                  input logic [1:0] idx,
                                                  input logic [7:0] d);
      logic [23:0] t;
      t = 24'(old);
      case (idx)
         2'd0:    t[7:0]   = d;
         2'd1:    t[15:8]  = d;
         default: t[23:16] = d;
      endcase
      return ADDR_W'(t);
   endfunction

   always_ff @(posedge CLK) begin
      if (RES) begin
         state      <= IDLE;
         ch         <= '0;
         ROM_REQ    <= 1'b0;
         ROM_ADDR   <= '0;
         OUT_VALID  <= 1'b0;
         OUT_CH     <= '0;
         OUT_SAMPLE <= '0;
         ACTIVE     <= '0;
         BUSY       <= 1'b0;
         OVERRUN    <= 1'b0;
         w_cur      <= '0;
         w_frac     <= '0;
         w_pitch    <= '0;
         w_mode     <= '0;
         w_active   <= 1'b0;
         w_end      <= 1'b0;
         w_lo       <= '0;
         dirty      <= 1'b0;
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            start_r[i] <= '0;
            loop_r[i]  <= '0;
            pitch_r[i] <= '0;
            mode_r[i]  <= '0;
            cur_r[i]   <= '0;
            frac_r[i]  <= '0;
         end
      end else begin
         if (SAMPLE_TICK && BUSY)
            OVERRUN <= 1'b1;

         case (state)
            IDLE: begin
               OUT_VALID <= 1'b0;
               if (SAMPLE_TICK) begin
                  ch    <= '0;
                  BUSY  <= 1'b1;
                  state <= SCAN;
               end
            end
            SCAN: begin
               w_cur    <= cur_r[ch];
               w_frac   <= frac_r[ch];
               w_pitch  <= pitch_r[ch];
               w_mode   <= mode_r[ch];
               w_active <= ACTIVE[ch];
               w_end    <= 1'b0;
               // A key write landing in this very cycle must also block writeback.
               dirty    <= key_hit && (wr_ch == ch);
               if (ACTIVE[ch]) begin
                  ROM_REQ  <= 1'b1;
                  ROM_ADDR <= cur_r[ch];
                  state    <= FETCH_LO;
               end else begin
                  OUT_VALID  <= 1'b1;
                  OUT_CH     <= 4'(ch);
                  OUT_SAMPLE <= '0;
                  state      <= EMIT;
               end
            end
            FETCH_LO: begin
               if (ROM_ACK) begin
                  w_lo <= ROM_DATA;
                  if (w_mode[0]) begin
                     ROM_ADDR <= w_cur + ADDR_W'(1);
                     state    <= FETCH_HI;
                  end else begin
                     ROM_REQ    <= 1'b0;
                     OUT_VALID  <= 1'b1;
                     OUT_CH     <= 4'(ch);
                     w_end      <= (ROM_DATA == 8'h80);
                     OUT_SAMPLE <= (ROM_DATA == 8'h80) ? 16'h0000 : {ROM_DATA, 8'h00};
                     state      <= EMIT;
                  end
               end
            end
            FETCH_HI: begin
               if (ROM_ACK) begin
                  ROM_REQ    <= 1'b0;
                  OUT_VALID  <= 1'b1;
                  OUT_CH     <= 4'(ch);
                  w_end      <= (hi_word == 16'h8000);
                  OUT_SAMPLE <= (hi_word == 16'h8000) ? 16'h0000 : hi_word;
                  state      <= EMIT;
               end
            end
            EMIT: begin
               OUT_VALID <= 1'b0;
               if (!dirty && w_active) begin
                  if (w_end) begin
                     if (w_mode[1]) cur_r[ch] <= loop_r[ch];
                     else           ACTIVE[ch] <= 1'b0;
                  end else begin
                     cur_r[ch]  <= w_cur + step;
                     frac_r[ch] <= sum[11:0];
                  end
               end
               if (ch == CH_W'(CHANNELS - 1)) begin
                  BUSY  <= 1'b0;
                  state <= IDLE;
               end else begin
                  ch    <= ch + CH_W'(1);
                  state <= SCAN;
               end
            end
            default: state <= IDLE;
         endcase

         if (BUSY && state != SCAN && key_hit && wr_ch == ch)
            dirty <= 1'b1;

         // Host writes come last so they win over a same-cycle writeback.
         if (wr_hit) begin
            case (REG_SEL)
               4'd0, 4'd1, 4'd2: start_r[wr_ch] <= set_byte(start_r[wr_ch], REG_SEL[1:0], REG_DATA);
               4'd3: loop_r[wr_ch] <= set_byte(loop_r[wr_ch], 2'd0, REG_DATA);
               4'd4: loop_r[wr_ch] <= set_byte(loop_r[wr_ch], 2'd1, REG_DATA);
               4'd5: loop_r[wr_ch] <= set_byte(loop_r[wr_ch], 2'd2, REG_DATA);
               4'd6: pitch_r[wr_ch][7:0]  <= REG_DATA;
               4'd7: pitch_r[wr_ch][15:8] <= REG_DATA;
               4'd8: mode_r[wr_ch] <= REG_DATA[1:0];
               4'd9: begin
                  ACTIVE[wr_ch] <= REG_DATA[0];
                  if (REG_DATA[0]) begin
                     cur_r[wr_ch]  <= start_r[wr_ch];
                     frac_r[wr_ch] <= '0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
